// File: rtl/rib_arbiter_pkg.sv
// Shared constants and types for the RIB master arbiter.
// Master indices, FSM states and the fixed priority order live here.
package rib_arbiter_pkg;

  localparam int RibMstNum = 4;

  localparam logic [1:0] MST_M0 = 2'd0;
  localparam logic [1:0] MST_M1 = 2'd1;
  localparam logic [1:0] MST_M2 = 2'd2;
  localparam logic [1:0] MST_M3 = 2'd3;

  localparam int STARVE_LIMIT_DEF = 15;

  // m1 (core fetch) owns the bus whenever nobody else does
  localparam logic [RibMstNum-1:0] GNT_DFLT = RibMstNum'(1) << MST_M1;

  typedef enum logic [1:0] {ARB, OWN, LOCK} arb_state_e;

  // rank 0 is the highest priority: m3 > m0 > m2 > m1
  function automatic logic [1:0] prio_at(input logic [1:0] rank);
    case (rank)
      2'd0:    return MST_M3;
      2'd1:    return MST_M0;
      2'd2:    return MST_M2;
      default: return MST_M1;
    endcase
  endfunction

endpackage

// File: rtl/rib_arb_pick.sv
// Combinational winner select: starved requesters first, then fixed priority.
// Output is always one-hot; defaults to m1 when nothing requests.
module rib_arb_pick
  import rib_arbiter_pkg::*;
(
  input  logic [RibMstNum-1:0] req,
  input  logic [RibMstNum-1:0] starved,
  output logic [RibMstNum-1:0] onehot,
  output logic [1:0]           idx,
  output logic                 any
);

  logic [RibMstNum-1:0] eff;

  always_comb begin
    eff = (|(req & starved)) ? (req & starved) : req;
    any = |req;
    idx = MST_M1;
    // walk lowest to highest rank so the best candidate is written last
    for (int r = RibMstNum - 1; r >= 0; r--) begin
      if (eff[prio_at(2'(r))]) idx = prio_at(2'(r));
    end
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rib_arbiter.sv
// RIB bus arbiter: registered one-hot grant, lock across busy slaves,
// and per-master starvation aging that promotes long-denied masters.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RibMstNum-1:0] req_i,
  input  logic                 busy_i,
  output logic [RibMstNum-1:0] grant_o,
  output logic [1:0]           grant_id_o,
  output logic                 grant_valid_o,
  output logic [RibMstNum-1:0] starve_o,
  output logic                 hold_flag_o
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

  arb_state_e state_q, state_d;
  logic [RibMstNum-1:0]            grant_q, grant_d;
  logic [1:0]                      id_q, id_d;
  logic                            valid_q, valid_d;
  logic [RibMstNum-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [RibMstNum-1:0]            starve_q, starve_d;
  logic [RibMstNum-1:0]            owner, pick_oh;
  logic [1:0]                      pick_idx;
  logic                            pick_any;

  assign owner = grant_q & {RibMstNum{valid_q}};

  // the completing owner's counter clears this edge, so it must not win on
  // a stale starved flag and hog the bus for a second transfer
  rib_arb_pick u_pick (
    .req     (req_i),
    .starved (starve_q & ~owner),
    .onehot  (pick_oh),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    logic rearb;
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    valid_d = valid_q;
    rearb   = 1'b0;
    case (state_q)
      ARB:       rearb = 1'b1;
      OWN, LOCK: if (busy_i) state_d = LOCK;
                 else        rearb   = 1'b1;
      default:   rearb = 1'b1;
    endcase
    if (rearb) begin
      if (pick_any) begin
        state_d = OWN;
        grant_d = pick_oh;
        id_d    = pick_idx;
        valid_d = 1'b1;
      end else begin
        state_d = ARB;
        grant_d = GNT_DFLT;
        id_d    = MST_M1;
        valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d    = '0;
    starve_d = '0;
    for (int n = 0; n < RibMstNum; n++) begin
      if (req_i[n]) begin
        if (state_q == ARB)
          cnt_d[n] = cnt_q[n];
        else if (!owner[n])
          cnt_d[n] = (cnt_q[n] == LIM) ? cnt_q[n] : cnt_q[n] + CNT_W'(1);
      end
      starve_d[n] = (cnt_d[n] == LIM);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB;
      grant_q  <= GNT_DFLT;
      id_q     <= MST_M1;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      id_q     <= id_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_id_o    = id_q;
  assign grant_valid_o = valid_q;
  assign starve_o      = starve_q;
  assign hold_flag_o   = (state_q == LOCK) | req_i[MST_M3] | req_i[MST_M0]
                       | req_i[MST_M2] | busy_i;

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter: reset, priority, lock, starvation,
// back-to-back and asynchronous reset during a locked access.
module tb_rib_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i;
  logic       busy_i;
  logic [3:0] grant_o;
  logic [1:0] grant_id_o;
  logic       grant_valid_o;
  logic [3:0] starve_o;
  logic       hold_flag_o;

  int passed = 0;
  int total  = 0;

  rib_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .busy_i        (busy_i),
    .grant_o       (grant_o),
    .grant_id_o    (grant_id_o),
    .grant_valid_o (grant_valid_o),
    .starve_o      (starve_o),
    .hold_flag_o   (hold_flag_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // leaves the DUT out of reset in ARB, just after a falling edge
  task automatic do_reset();
    req_i  = 4'b0000;
    busy_i = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_i = 4'b1111; busy_i = 1'b0;
    @(negedge clk);
    total++; if (grant_o !== 4'b0010) $display("FAIL rst_grant got %b exp 0010", grant_o); else passed++;
    total++; if (grant_id_o !== 2'd1) $display("FAIL rst_id got %0d exp 1", grant_id_o); else passed++;
    total++; if (grant_valid_o !== 1'b0) $display("FAIL rst_valid got %b exp 0", grant_valid_o); else passed++;
    total++; if (starve_o !== 4'b0000) $display("FAIL rst_starve got %b exp 0000", starve_o); else passed++;
    total++; if (hold_flag_o !== 1'b1) $display("FAIL rst_hold got %b exp 1", hold_flag_o); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if (grant_o !== 4'b1000) $display("FAIL rst_rel_grant got %b exp 1000", grant_o); else passed++;
    total++; if (grant_id_o !== 2'd3) $display("FAIL rst_rel_id got %0d exp 3", grant_id_o); else passed++;
    total++; if (grant_valid_o !== 1'b1) $display("FAIL rst_rel_valid got %b exp 1", grant_valid_o); else passed++;
  endtask

  task automatic test_priority();
    do_reset();
    req_i = 4'b0101;
    @(negedge clk);
    total++; if (grant_o !== 4'b0001) $display("FAIL prio_m0 got %b exp 0001", grant_o); else passed++;
    total++; if (grant_id_o !== 2'd0) $display("FAIL prio_m0_id got %0d exp 0", grant_id_o); else passed++;
    req_i = 4'b0100;
    @(negedge clk);
    total++; if (grant_o !== 4'b0100) $display("FAIL prio_m2 got %b exp 0100", grant_o); else passed++;
    total++; if (grant_id_o !== 2'd2) $display("FAIL prio_m2_id got %0d exp 2", grant_id_o); else passed++;
    req_i = 4'b1110;
    @(negedge clk);
    total++; if (grant_o !== 4'b1000) $display("FAIL prio_m3 got %b exp 1000", grant_o); else passed++;
    req_i = 4'b0000;
    @(negedge clk);
    total++; if (grant_o !== 4'b0010) $display("FAIL prio_idle_grant got %b exp 0010", grant_o); else passed++;
    total++; if (grant_valid_o !== 1'b0) $display("FAIL prio_idle_valid got %b exp 0", grant_valid_o); else passed++;
    total++; if (hold_flag_o !== 1'b0) $display("FAIL prio_idle_hold got %b exp 0", hold_flag_o); else passed++;
    req_i = 4'b0010;
    #1;
    total++; if (hold_flag_o !== 1'b0) $display("FAIL prio_m1_hold got %b exp 0", hold_flag_o); else passed++;
    @(negedge clk);
    total++; if (grant_valid_o !== 1'b1) $display("FAIL prio_m1_valid got %b exp 1", grant_valid_o); else passed++;
  endtask

  task automatic test_lock();
    do_reset();
    req_i = 4'b1000;
    @(negedge clk);
    total++; if (grant_o !== 4'b1000) $display("FAIL lock_own got %b exp 1000", grant_o); else passed++;
    busy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_i = (i % 2 == 0) ? 4'b1111 : 4'b0101;
      @(negedge clk);
      total++; if (grant_o !== 4'b1000) $display("FAIL lock_frozen[%0d] got %b exp 1000", i, grant_o); else passed++;
      total++; if (hold_flag_o !== 1'b1) $display("FAIL lock_hold[%0d] got %b exp 1", i, hold_flag_o); else passed++;
    end
    total++; if (dut.state_q !== 2'd2) $display("FAIL lock_state got %0d exp 2", dut.state_q); else passed++;
    // completion cycle: grant still held, LOCK alone keeps hold high
    busy_i = 1'b0; req_i = 4'b0010;
    #1;
    total++; if (grant_o !== 4'b1000) $display("FAIL lock_complete got %b exp 1000", grant_o); else passed++;
    total++; if (hold_flag_o !== 1'b1) $display("FAIL lock_complete_hold got %b exp 1", hold_flag_o); else passed++;
    req_i = 4'b0101;
    @(negedge clk);
    total++; if (grant_o !== 4'b0001) $display("FAIL lock_rearb got %b exp 0001", grant_o); else passed++;
    total++; if (dut.state_q !== 2'd1) $display("FAIL lock_exit_state got %0d exp 1", dut.state_q); else passed++;
  endtask

  task automatic test_starvation();
    do_reset();
    req_i = 4'b1010;
    @(negedge clk);
    total++; if (grant_o !== 4'b1000) $display("FAIL starve_first got %b exp 1000", grant_o); else passed++;
    for (int i = 2; i <= 15; i++) begin
      @(negedge clk);
      total++; if (grant_o !== 4'b1000 || starve_o !== 4'b0000)
        $display("FAIL starve_deny[%0d] got grant %b starve %b exp 1000 0000", i, grant_o, starve_o);
      else passed++;
    end
    @(negedge clk);
    total++; if (starve_o !== 4'b0010) $display("FAIL starve_flag got %b exp 0010", starve_o); else passed++;
    total++; if (grant_o !== 4'b1000) $display("FAIL starve_flag_grant got %b exp 1000", grant_o); else passed++;
    @(negedge clk);
    total++; if (grant_o !== 4'b0010) $display("FAIL starve_promote got %b exp 0010", grant_o); else passed++;
    total++; if (grant_valid_o !== 1'b1) $display("FAIL starve_promote_valid got %b exp 1", grant_valid_o); else passed++;
    @(negedge clk);
    total++; if (grant_o !== 4'b1000) $display("FAIL starve_return got %b exp 1000", grant_o); else passed++;
    total++; if (starve_o !== 4'b0000) $display("FAIL starve_clear got %b exp 0000", starve_o); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_i = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (grant_o !== 4'b0001 || grant_valid_o !== 1'b1)
        $display("FAIL b2b[%0d] got grant %b valid %b exp 0001 1", i, grant_o, grant_valid_o);
      else passed++;
    end
    req_i = 4'b0000;
    @(negedge clk);
    total++; if (grant_o !== 4'b0010) $display("FAIL b2b_idle_grant got %b exp 0010", grant_o); else passed++;
    total++; if (grant_valid_o !== 1'b0) $display("FAIL b2b_idle_valid got %b exp 0", grant_valid_o); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    req_i = 4'b1000;
    @(negedge clk);
    busy_i = 1'b1; req_i = 4'b1010;
    @(negedge clk);
    @(negedge clk);
    total++; if (grant_o !== 4'b1000) $display("FAIL ares_locked got %b exp 1000", grant_o); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (grant_o !== 4'b0010) $display("FAIL ares_grant got %b exp 0010", grant_o); else passed++;
    total++; if (grant_valid_o !== 1'b0) $display("FAIL ares_valid got %b exp 0", grant_valid_o); else passed++;
    total++; if (dut.cnt_q !== '0) $display("FAIL ares_cnt got %h exp 0", dut.cnt_q); else passed++;
    total++; if (starve_o !== 4'b0000) $display("FAIL ares_starve got %b exp 0000", starve_o); else passed++;
    @(negedge clk);
    req_i = 4'b0000; busy_i = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_lock();
    test_starvation();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
